// File: rtl/ser_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ser_loader_pkg
// Purpose : Shared types and helpers for the serial-to-parallel loader.
//           Holds the three-state FSM encoding and the bit-counter width
//           helper used by ser_loader and bit_counter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ser_loader_pkg;

    // Loader FSM: wait for start, collect W bits, present the word for one cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Counter must be able to represent the value W itself, hence W+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffe.sv
`default_nettype none
// ============================================================================
// Module  : dffe
// Purpose : Bank of W D flip-flops with individual write enables; the
//           downstream register that ser_loader writes into.
// Ports   : clk  - rising-edge clock
//           clrn - asynchronous active-low reset
//           d    - data in
//           ena  - per-bit write enable
//           q    - registered data out
// Revision: 1.0 - initial release
// ============================================================================
module dffe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] d,
    input  logic [W-1:0] ena,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else begin
            q <= (ena & d) | (~ena & q);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ser_loader_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : bit_counter
// Purpose : Counts sampled serial bits of one word. Synchronous clear,
//           increment that saturates at W (never wraps inside a word), and a
//           terminal-count flag that fires on the increment bringing the
//           count to W, so the parent can move to LOAD on that same edge.
// Ports   : clk   - rising-edge clock
//           clrn  - asynchronous active-low reset
//           clear - synchronous clear to zero
//           inc   - count one bit this cycle
//           tc    - this increment completes the W-th bit
// Revision: 1.0 - initial release
// ============================================================================
module bit_counter
    import ser_loader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic clrn,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] FULL = CW'(W);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != FULL)) begin
            count <= count + 1'b1;
        end
    end

    // Flags the W-th bit as it is being sampled rather than one cycle later,
    // which keeps the sample-to-load latency at a single cycle.
    assign tc = inc && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ser_loader.sv
`default_nettype none
// ============================================================================
// Module  : ser_loader
// Purpose : Assembles W serially presented bits into a parallel word and
//           writes it into a downstream DFFE bank with a one-cycle all-ones
//           enable pulse. Supports MSB-first or LSB-first bit order, gaps
//           between bits (bit_en low) and abort of a word in progress.
// Ports   : clk    - rising-edge clock
//           clrn   - asynchronous active-low reset
//           start  - begin assembling a word (accepted in IDLE only)
//           abort  - cancel the word in progress (honoured in SHIFT only)
//           bit_en - sdi is valid this cycle
//           sdi    - serial data
//           d      - assembled word to DFFE d (holds last loaded value)
//           ena    - per-bit enable to DFFE ena (all-ones in LOAD)
//           busy   - high in SHIFT and LOAD
//           done   - one-cycle pulse coincident with ena
// Revision: 1.0 - initial release
// ============================================================================
module ser_loader
    import ser_loader_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         start,
    input  logic         abort,
    input  logic         bit_en,
    input  logic         sdi,
    output logic [W-1:0] d,
    output logic [W-1:0] ena,
    output logic         busy,
    output logic         done
);

    state_t       state;
    logic [W-1:0] sr;
    logic [W-1:0] shifted;
    logic         cnt_clear;
    logic         cnt_inc;
    logic         last_bit;

    // After W shifts the first bit has travelled to d[W-1] (MSB first)
    // or to d[0] (LSB first).
    generate
        if (W == 1) begin : g_single
            assign shifted = sdi;
        end else if (MSB_FIRST) begin : g_msb_first
            assign shifted = {sr[W-2:0], sdi};
        end else begin : g_lsb_first
            assign shifted = {sdi, sr[W-1:1]};
        end
    endgenerate

    // Counter is held clear throughout IDLE, so it starts from zero on entry
    // to SHIFT. Abort wins over a same-cycle bit, which is then discarded.
    assign cnt_clear = (state == IDLE);
    assign cnt_inc   = (state == SHIFT) && bit_en && !abort;

    bit_counter #(
        .W (W)
    ) u_bit_counter (
        .clk   (clk),
        .clrn  (clrn),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (last_bit)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            sr    <= '0;
            d     <= '0;
            ena   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ena  <= '0;
                    done <= 1'b0;
                    // bit_en is ignored here even when start is accepted.
                    if (start && !abort) begin
                        state <= SHIFT;
                        sr    <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (bit_en) begin
                        sr <= shifted;
                        if (last_bit) begin
                            // Register the completed word straight into the
                            // outputs so LOAD presents it with no extra cycle.
                            state <= LOAD;
                            d     <= shifted;
                            ena   <= '1;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // start and abort are both ignored; the load always ends.
                    state <= IDLE;
                    ena   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ena   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ser_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_ser_loader
// Purpose : Self-checking bench for ser_loader. Three configurations share
//           one stimulus stream: W=8 MSB-first, W=8 LSB-first and W=1. Each
//           drives a dffe bank. A word-level reference model predicts every
//           output every cycle; a vector table and directed sequences pin
//           down the named scenarios, followed by random traffic.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ser_loader;

    logic clk    = 1'b0;
    logic clrn   = 1'b0;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic bit_en = 1'b0;
    logic sdi    = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] d_m, ena_m, q_m, d_l, ena_l, q_l;
    logic [0:0] d_1, ena_1, q_1;
    logic       busy_m, done_m, busy_l, done_l, busy_1, done_1;

    ser_loader #(.W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort), .bit_en(bit_en),
        .sdi(sdi), .d(d_m), .ena(ena_m), .busy(busy_m), .done(done_m));
    dffe #(.W(8)) u_reg_msb (.clk(clk), .clrn(clrn), .d(d_m), .ena(ena_m), .q(q_m));

    ser_loader #(.W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort), .bit_en(bit_en),
        .sdi(sdi), .d(d_l), .ena(ena_l), .busy(busy_l), .done(done_l));
    dffe #(.W(8)) u_reg_lsb (.clk(clk), .clrn(clrn), .d(d_l), .ena(ena_l), .q(q_l));

    ser_loader #(.W(1), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort), .bit_en(bit_en),
        .sdi(sdi), .d(d_1), .ena(ena_1), .busy(busy_1), .done(done_1));
    dffe #(.W(1)) u_reg_one (.clk(clk), .clrn(clrn), .d(d_1), .ena(ena_1), .q(q_1));

    logic [63:0] a_d [3];
    logic [63:0] a_ena [3];
    logic [63:0] a_q [3];
    logic        a_busy [3];
    logic        a_done [3];

    assign a_d[0]   = 64'(d_m);   assign a_d[1]   = 64'(d_l);   assign a_d[2]   = 64'(d_1);
    assign a_ena[0] = 64'(ena_m); assign a_ena[1] = 64'(ena_l); assign a_ena[2] = 64'(ena_1);
    assign a_q[0]   = 64'(q_m);   assign a_q[1]   = 64'(q_l);   assign a_q[2]   = 64'(q_1);
    assign a_busy[0] = busy_m;    assign a_busy[1] = busy_l;    assign a_busy[2] = busy_1;
    assign a_done[0] = done_m;    assign a_done[1] = done_l;    assign a_done[2] = done_1;

    int tests = 0;
    int fails = 0;
    int ena_pulses [3];

    // ---------------- word-level reference model ----------------
    typedef struct {
        logic        busy;   // a word is in progress or being loaded
        logic        load;   // word is being presented this cycle
        int          n;      // bits collected so far
        logic [63:0] word;   // word value built arithmetically
        logic [63:0] d;      // last loaded word
        logic [63:0] q;      // downstream register contents
    } mdl_t;

    mdl_t mdl [3];
    int   cfg_w [3];
    bit   cfg_msb [3];

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic mdl_t mstep(input mdl_t s, input int w, input bit msbf,
                                   input logic st, input logic ab,
                                   input logic be, input logic di);
        mdl_t r;
        r = s;
        if (s.load) begin
            r.q    = s.d;
            r.load = 1'b0;
            r.busy = 1'b0;
        end else if (s.busy) begin
            if (ab) begin
                r.busy = 1'b0;
            end else if (be) begin
                if (msbf) r.word = s.word * 2 + 64'(di);
                else      r.word = s.word + (64'(di) << s.n);
                r.n = s.n + 1;
                if (r.n == w) begin
                    r.load = 1'b1;
                    r.d    = r.word & wmask(w);
                end
            end
        end else if (st && !ab) begin
            r.busy = 1'b1;
            r.n    = 0;
            r.word = '0;
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_i%0d_busy", tag, k), 64'(a_busy[k]), 64'(mdl[k].busy));
            chk($sformatf("%s_i%0d_done", tag, k), 64'(a_done[k]), 64'(mdl[k].load));
            chk($sformatf("%s_i%0d_ena", tag, k), a_ena[k], mdl[k].load ? wmask(cfg_w[k]) : 64'd0);
            chk($sformatf("%s_i%0d_d", tag, k), a_d[k], mdl[k].d);
            chk($sformatf("%s_i%0d_q", tag, k), a_q[k], mdl[k].q);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mdl[k] = '{default: '0};
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs are
    // compared 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!clrn) model_reset();
        else for (int k = 0; k < 3; k++)
            mdl[k] = mstep(mdl[k], cfg_w[k], cfg_msb[k], start, abort, bit_en, sdi);
        #1;
        for (int k = 0; k < 3; k++) if (a_ena[k] != 64'd0) ena_pulses[k]++;
        check_all(tag);
    endtask

    task automatic drive(input logic st, input logic ab, input logic be, input logic di);
        start = st; abort = ab; bit_en = be; sdi = di;
    endtask

    task automatic send_word(input logic [7:0] v, input int gap, input logic st_during);
        for (int i = 7; i >= 0; i--) begin
            drive(st_during, 1'b0, 1'b1, v[i]);
            cycle("bits");
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)));
                cycle("gap");
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges, checked before any further edge, held
    // for two clocks and released between edges.
    task automatic async_reset(input string tag);
        #2;
        clrn = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle("in_reset");
        #2;
        clrn = 1'b1;
    endtask

    task automatic clear_pulses();
        for (int k = 0; k < 3; k++) ena_pulses[k] = 0;
    endtask

    // ---------------- vector table: basic MSB/LSB load ----------------
    typedef struct {
        logic       st, ab, be, di;
        logic       busy;
        logic [7:0] ena;
        logic       done;
        logic [7:0] dm;
        logic [7:0] dl;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [7:0] pat;
        pat = 8'hA6;
        cfg_w[0] = 8; cfg_msb[0] = 1'b1;
        cfg_w[1] = 8; cfg_msb[1] = 1'b0;
        cfg_w[2] = 1; cfg_msb[2] = 1'b1;
        model_reset();
        clear_pulses();

        tbl[0] = '{st:1'b1, ab:1'b0, be:1'b0, di:1'b0, busy:1'b1, ena:8'h00, done:1'b0, dm:8'h00, dl:8'h00};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{st:1'b0, ab:1'b0, be:1'b1, di:pat[8 - i], busy:1'b1, ena:8'h00,
                       done:1'b0, dm:8'h00, dl:8'h00};
        tbl[8].ena = 8'hFF; tbl[8].done = 1'b1; tbl[8].dm = 8'hA6; tbl[8].dl = 8'h65;
        tbl[9] = '{st:1'b0, ab:1'b0, be:1'b0, di:1'b0, busy:1'b0, ena:8'h00, done:1'b0, dm:8'hA6, dl:8'h65};

        // Reset state
        repeat (2) cycle("reset");
        chk("reset_busy", 64'(busy_m), 64'd0);
        chk("reset_d", 64'(d_m), 64'd0);
        #2;
        clrn = 1'b1;

        // Basic load; row 0 is the first edge after release
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].be, tbl[i].di);
            cycle("tbl");
            chk($sformatf("tbl%0d_busy", i), 64'(busy_m), 64'(tbl[i].busy));
            chk($sformatf("tbl%0d_ena", i), 64'(ena_m), 64'(tbl[i].ena));
            chk($sformatf("tbl%0d_done", i), 64'(done_m), 64'(tbl[i].done));
            chk($sformatf("tbl%0d_dm", i), 64'(d_m), 64'(tbl[i].dm));
            chk($sformatf("tbl%0d_dl", i), 64'(d_l), 64'(tbl[i].dl));
        end
        chk("basic_q", 64'(q_m), 64'hA6);

        // LSB-first with gaps: exactly one enable pulse
        clear_pulses();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gaps_start");
        send_word(8'hA6, 1, 1'b0);
        repeat (2) cycle("gaps_tail");
        chk("gaps_d_lsb", 64'(d_l), 64'h65);
        chk("gaps_pulses", 64'(ena_pulses[1]), 64'd1);

        // Abort after five bits, then a full word
        clear_pulses();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("abort_start");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            cycle("abort_bits");
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        cycle("abort");
        chk("abort_busy", 64'(busy_m), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("abort_idle");
        chk("abort_no_ena", 64'(ena_pulses[0]), 64'd0);
        chk("abort_d_kept", 64'(d_m), 64'hA6);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        cycle("reload_start");
        send_word(8'h1D, 0, 1'b0);
        cycle("reload_tail");
        chk("reload_d_msb", 64'(d_m), 64'h1D);
        chk("reload_d_lsb", 64'(d_l), 64'(rev8(8'h1D)));

        // Simultaneous events
        drive(1'b1, 1'b0, 1'b1, 1'b1);           // bit with start is not sampled
        cycle("sim_start");
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);       // start in SHIFT is ignored
            cycle("sim_bits");
        end
        chk("sim_no_early_load", 64'(ena_m), 64'd0);
        chk("sim_busy", 64'(busy_m), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        cycle("sim_last");
        chk("sim_load_ena", 64'(ena_m), 64'hFF);
        chk("sim_load_d", 64'(d_m), 64'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("sim_idle");
        drive(1'b1, 1'b1, 1'b0, 1'b0);           // abort beats start in IDLE
        cycle("sim_abort_start");
        chk("sim_abort_start_busy", 64'(busy_m), 64'd0);

        // W=1: first load a 0, then a single 1 bit
        drive(1'b1, 1'b0, 1'b0, 1'b0); cycle("w1_a");
        drive(1'b0, 1'b0, 1'b1, 1'b0); cycle("w1_b");
        drive(1'b0, 1'b0, 1'b0, 1'b0); cycle("w1_c");
        chk("w1_d_zero", 64'(d_1), 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0); cycle("w1_start");
        drive(1'b0, 1'b0, 1'b1, 1'b1); cycle("w1_bit");
        chk("w1_ena", 64'(ena_1), 64'd1);
        chk("w1_d", 64'(d_1), 64'd1);
        chk("w1_done", 64'(done_1), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); cycle("w1_idle");

        // Asynchronous reset after three bits
        drive(1'b1, 1'b0, 1'b0, 1'b0); cycle("rst_start");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            cycle("rst_bits");
        end
        async_reset("async");
        chk("async_q", 64'(q_m), 64'd0);
        clear_pulses();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
            cycle("post_rst");
        end
        chk("post_rst_no_ena", 64'(ena_pulses[0] + ena_pulses[1] + ena_pulses[2]), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(99) < 25), 1'($urandom_range(99) < 4),
                  1'($urandom_range(99) < 60), 1'($urandom_range(1)));
            cycle("rand");
            if ($urandom_range(499) == 0) async_reset("rand_async");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
